// File: rtl/imem_loader.sv
// Byte-stream program loader: takes a 16-bit little-endian word-count header,
// then packs each group of four stream bytes little-endian into a word and
// writes it to the IMEM at consecutive word addresses from BASE_ADDR.
// cpu_hold keeps the core in reset for the duration of a load.
module imem_loader #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned         MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [PC_WIDTH-1:0]   wr_addr,
  output logic [INST_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_written,
  output logic                  cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             count_q, count_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [INST_WIDTH-1:0]   word_q, word_d;
  logic                    wr_en_q, wr_en_d;
  logic [PC_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [INST_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    rx_ready_q, rx_ready_d;
  logic [15:0]             words_written_q, words_written_d;
  logic [15:0]             hdr_count;
  logic                    accept;

  assign accept = rx_valid && rx_ready_q;

  // State register and registered outputs; reset discards any partial load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      count_q         <= '0;
      byte_idx_q      <= '0;
      word_q          <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      rx_ready_q      <= 1'b0;
      words_written_q <= '0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      byte_idx_q      <= byte_idx_d;
      word_q          <= word_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      rx_ready_q      <= rx_ready_d;
      words_written_q <= words_written_d;
    end
  end

  // Next-state and next-output logic. Outputs are registered, so the
  // write strobe, address and data are prepared on the edge that accepts
  // the 4th byte and rx_ready/busy are derived from the next state.
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    byte_idx_d      = byte_idx_q;
    word_d          = word_q;
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    done_d          = done_q;
    err_d           = err_q;
    words_written_d = words_written_q;
    hdr_count       = {rx_data, count_q[7:0]};

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d         = S_HDR0;
          done_d          = 1'b0;
          err_d           = 1'b0;
          words_written_d = '0;
        end
      end
      S_HDR0: begin
        if (accept) begin
          count_d[7:0] = rx_data;
          state_d      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          count_d = hdr_count;
          if (hdr_count == 16'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if ({1'b0, hdr_count} > 17'(MAX_WORDS)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            wr_data_d = word_d;
            wr_addr_d = BASE_ADDR + PC_WIDTH'({words_written_q, 2'b00});
          end
        end
      end
      S_WRITE: begin
        words_written_d = words_written_q + 16'd1;
        if (({1'b0, words_written_q} + 17'd1) < {1'b0, count_q}) begin
          state_d = S_DATA;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                 (state_d == S_DATA) || (state_d == S_WRITE);
    rx_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                 (state_d == S_DATA);
  end

  assign rx_ready      = rx_ready_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = words_written_q;
  assign cpu_hold      = busy_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: drives byte streams with random
// valid gaps and compares the captured IMEM writes and status against
// expectations computed from the header/byte stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_written;
  logic        cpu_hold;

  imem_loader #(
    .PC_WIDTH  (32),
    .INST_WIDTH(32),
    .BASE_ADDR (32'h0),
    .MAX_WORDS (256)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_written(words_written),
    .cpu_hold     (cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int ready_viol = 0;
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe; a write cycle must never also accept a byte.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
      if (rx_ready !== 1'b0) ready_viol = ready_viol + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Presents one byte (after an optional random idle gap) and waits for it
  // to be accepted; returns on the falling edge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 64; t++) begin
      if (rx_ready === 1'b1) begin
        @(negedge clk);
        rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    checks++; fails++;
    $display("FAIL byte_accept_timeout: rx_ready=%b, required 1 within 64 cycles", rx_ready);
  endtask

  // Full load: start pulse, stream, then compare against the stream's meaning.
  task automatic load(input logic [7:0] s[$], input int max_gap, input bit junk, input string nm);
    int cnt, nw, base, v0, c0;
    bit exp_err;
    logic [31:0] ed;
    cnt     = int'(s[0]) + 256 * int'(s[1]);
    exp_err = cnt > 256;
    nw      = exp_err ? 0 : cnt;
    base    = cap_addr.size();
    v0      = ready_viol;
    c0      = 0;
    if (junk) begin rx_valid = 1'b1; rx_data = 8'hFF; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rx_valid = 1'b0;
    checks++;
    if ({busy, cpu_hold, rx_ready, done, err} !== 5'b11100 || words_written !== 16'h0) begin
      fails++;
      $display("FAIL %s start_state: busy/hold/ready/done/err=%b ww=%0d, required 11100 ww=0",
               nm, {busy, cpu_hold, rx_ready, done, err}, words_written);
    end
    for (int i = 0; i < s.size(); i++) begin
      if (i == 2) c0 = cyc;
      send_byte(s[i], max_gap);
      if (i >= 2 && ((i - 2) % 4) == 3) begin
        checks++;
        if (wr_en !== 1'b1) begin
          fails++;
          $display("FAIL %s write_latency word %0d: wr_en=%b, required 1", nm, (i - 2) / 4, wr_en);
        end
      end
    end
    if (nw == 0) begin
      checks++;
      if ({done, err} !== {!exp_err, exp_err}) begin
        fails++;
        $display("FAIL %s header_end: done=%b err=%b, required done=%b err=%b",
                 nm, done, err, !exp_err, exp_err);
      end
    end
    if (max_gap == 0 && nw > 0) begin
      checks++;
      if (cyc - c0 != 5 * nw - 1) begin
        fails++;
        $display("FAIL %s throughput: %0d cycles, required %0d", nm, cyc - c0, 5 * nw - 1);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (cap_addr.size() - base != nw) begin
      fails++;
      $display("FAIL %s write_count: %0d, required %0d", nm, cap_addr.size() - base, nw);
    end
    for (int w = 0; w < nw && base + w < cap_addr.size(); w++) begin
      ed = {s[2 + 4*w + 3], s[2 + 4*w + 2], s[2 + 4*w + 1], s[2 + 4*w]};
      checks++;
      if (cap_addr[base + w] !== 32'(4 * w) || cap_data[base + w] !== ed) begin
        fails++;
        $display("FAIL %s write %0d: addr=%h data=%h, required addr=%h data=%h",
                 nm, w, cap_addr[base + w], cap_data[base + w], 32'(4 * w), ed);
      end
    end
    checks++;
    if ({done, err, busy, cpu_hold, rx_ready, wr_en} !== {!exp_err, exp_err, 4'b0000}) begin
      fails++;
      $display("FAIL %s final_status: done/err/busy/hold/ready/wr_en=%b, required %b",
               nm, {done, err, busy, cpu_hold, rx_ready, wr_en}, {!exp_err, exp_err, 4'b0000});
    end
    checks++;
    if (words_written !== 16'(nw)) begin
      fails++;
      $display("FAIL %s words_written: %0d, required %0d", nm, words_written, nw);
    end
    checks++;
    if (ready_viol != v0) begin
      fails++;
      $display("FAIL %s ready_in_write: %0d write cycles with rx_ready=1, required 0", nm, ready_viol - v0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_ready, wr_en, wr_addr, wr_data, busy, done, err, words_written, cpu_hold} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b wr_en=%b addr=%h data=%h busy=%b done=%b err=%b ww=%0d hold=%b, required all 0",
               rx_ready, wr_en, wr_addr, wr_data, busy, done, err, words_written, cpu_hold);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] s[$];
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(s, 0, 1'b0, "basic");
  endtask

  task automatic test_empty();
    logic [7:0] s[$];
    s = '{8'h00, 8'h00};
    load(s, 0, 1'b0, "empty");
  endtask

  task automatic test_boundary();
    logic [7:0] s[$];
    s = '{8'h01, 8'h01};
    load(s, 0, 1'b0, "reject_257");
    s = '{8'h00, 8'h01};
    for (int i = 0; i < 4 * 256; i++) s.push_back(8'($urandom));
    load(s, 0, 1'b0, "max_256");
    s = '{8'($urandom), 8'($urandom_range(255, 2))};
    load(s, 1, 1'b0, "reject_random");
  endtask

  task automatic test_gaps();
    logic [7:0] s[$];
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(s, 3, 1'b0, "basic_gaps");
    for (int n = 0; n < 6; n++) begin
      int cnt;
      cnt = int'($urandom_range(6, 1));
      s = '{8'(cnt), 8'h00};
      for (int i = 0; i < 4 * cnt; i++) s.push_back(8'($urandom));
      load(s, 4, 1'b0, "random_gaps");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[$];
    s = '{8'h03, 8'h00};
    for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
    load(s, 0, 1'b1, "back_to_back_junk_start");
  endtask

  task automatic test_reset_midload();
    logic [7:0] s[$];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    #1;
    checks++;
    if ({rx_ready, wr_en, wr_addr, wr_data, busy, done, err, words_written, cpu_hold} !== '0) begin
      fails++;
      $display("FAIL midload_reset: ready=%b busy=%b ww=%0d hold=%b, required all outputs 0",
               rx_ready, busy, words_written, cpu_hold);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(s, 2, 1'b0, "after_reset");
  endtask

  task automatic test_start_ignored();
    int base;
    base = cap_addr.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, rx_ready, done} !== 3'b110) begin
      fails++;
      $display("FAIL start_in_data: busy/ready/done=%b, required 110", {busy, rx_ready, done});
    end
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (cap_addr.size() - base != 1) begin
      fails++;
      $display("FAIL start_in_data_count: %0d writes, required 1", cap_addr.size() - base);
    end else begin
      checks++;
      if (cap_addr[base] !== 32'h0 || cap_data[base] !== 32'h44332211) begin
        fails++;
        $display("FAIL start_in_data_write: addr=%h data=%h, required 00000000 44332211",
                 cap_addr[base], cap_data[base]);
      end
    end
    checks++;
    if ({done, busy} !== 2'b10 || words_written !== 16'd1) begin
      fails++;
      $display("FAIL start_in_data_final: done=%b busy=%b ww=%0d, required 1 0 1", done, busy, words_written);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_boundary();
    test_gaps();
    test_back_to_back();
    test_reset_midload();
    test_start_ignored();
    test_basic();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
